// File: rtl/vga_fb_scanout.sv
// Pixel scanout: fetches 4x-upscaled palette indices from a double-buffered framebuffer,
// maps them through a writable RGB444 palette and keeps sync/de aligned with colour.
module vga_fb_scanout #(
    parameter int FB_W   = 200,
    parameter int FB_H   = 150,
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 4
) (
    input  logic              clk_pix,
    input  logic              rst_pix_n,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              de_in,
    input  logic              frame_in,
    output logic              fb_rd_en,
    output logic [ADDR_W:0]   fb_addr,
    input  logic [PIX_W-1:0]  fb_rdata,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              buf_sel,
    input  logic              pal_we,
    input  logic [PIX_W-1:0]  pal_idx,
    input  logic [11:0]       pal_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_de
);
    localparam int STAGES = 3;
    localparam int PAL_N  = 2**PIX_W;

    typedef enum logic {IDLE, PENDING} swap_state_t;

    logic [7:0]        fx, fy;
    logic [ADDR_W-1:0] lin;
    logic              unused_bits;

    assign fx = sx[9:2];
    assign fy = sy[9:2];
    assign unused_bits = ^{sx[1:0], sy[1:0]};

    // fy*200 as shifts for the standard geometry; other sizes fall back to a multiply
    if (FB_W == 200 && FB_W * FB_H <= 2**ADDR_W) begin : g_shift_add
        assign lin = ADDR_W'({fy, 7'b0}) + ADDR_W'({fy, 6'b0}) + ADDR_W'({fy, 3'b0}) + ADDR_W'(fx);
    end else begin : g_mult
        assign lin = ADDR_W'(int'(fy) * FB_W + int'(fx));
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
        end else begin
            fb_rd_en <= de_in;
            if (de_in) fb_addr <= {buf_sel, lin};
        end
    end

    logic [STAGES:1] vld_pipe, hs_pipe, vs_pipe;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            vld_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], de_in};
            hs_pipe  <= {hs_pipe[STAGES-1:1], hsync_in};
            vs_pipe  <= {vs_pipe[STAGES-1:1], vsync_in};
        end
    end

    assign vga_de    = vld_pipe[STAGES];
    assign vga_hsync = hs_pipe[STAGES];
    assign vga_vsync = vs_pipe[STAGES];

    logic [11:0] pal [PAL_N];
    logic [11:0] rgb_q;

    // Lookup and write share the edge, so a same-cycle write is seen one pixel later
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            for (int i = 0; i < PAL_N; i++) pal[i] <= 12'({3{PIX_W'(i)}});
            rgb_q <= '0;
        end else begin
            if (pal_we) pal[pal_idx] <= pal_data;
            rgb_q <= vld_pipe[STAGES-1] ? pal[fb_rdata] : 12'h000;
        end
    end

    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];

    swap_state_t state, state_nxt;
    logic        swap_fire;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state    <= IDLE;
            buf_sel  <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            buf_sel  <= buf_sel ^ swap_fire;
            swap_ack <= swap_fire;
        end
    end

    // A request seen during the ack pulse is the one just served, not a new one
    always_comb begin
        state_nxt = state;
        swap_fire = 1'b0;
        case (state)
            IDLE: begin
                if (swap_req && !swap_ack) begin
                    if (frame_in) swap_fire = 1'b1;
                    else          state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (frame_in) swap_fire = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (swap_fire) state_nxt = IDLE;
    end
endmodule
